// File: rtl/dmem_pkg.sv
// Shared widths and state encoding for the data-memory copy engine.
package dmem_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Selects who drives the single memory port: the CPU while idle, the copy engine otherwise.
module dmem_port_mux
    import dmem_pkg::*;
#(
    parameter int AW = dmem_pkg::AW,
    parameter int DW = dmem_pkg::DW
) (
    input  logic        rst_n,
    input  copy_state_t state,
    input  logic        cpu_wr_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dat_in,
    input  logic [AW-1:0] src_ptr,
    input  logic [AW-1:0] dst_ptr,
    input  logic [DW-1:0] data_buf,
    output logic        mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in
);

    logic wr_raw;

    // Decode memory drive from the engine state; CPU address/data are the idle default.
    always_comb begin
        wr_raw     = 1'b0;
        mem_addr   = cpu_addr;
        mem_dat_in = cpu_dat_in;
        case (state)
            IDLE:  wr_raw = cpu_wr_en;
            READ:  mem_addr = src_ptr;
            WRITE: begin
                mem_addr   = dst_ptr;
                mem_dat_in = data_buf;
                wr_raw     = 1'b1;
            end
            DONE:    wr_raw = 1'b0;
            default: wr_raw = 1'b0;
        endcase
    end

    // Reset kills the write strobe immediately, even before the state register settles.
    assign mem_wr_en = wr_raw & rst_n;

endmodule

// File: rtl/dmem_copy_engine.sv
// Block-copy engine owning the data-memory port; CPU passes through while idle.
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int AW = dmem_pkg::AW,
    parameter int DW = dmem_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic          cpu_wr_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dat_in,
    input  logic [DW-1:0] mem_dat_out,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    output logic          busy,
    output logic          done
);

    copy_state_t   state, state_nxt;
    logic [AW-1:0] src_ptr, dst_ptr, count;
    logic [DW-1:0] data_buf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: one read/write pair per byte; a zero-length start goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? READ : DONE;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (count == AW'(1)) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, capture the read byte, advance pointers after each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_buf <= '0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    src_ptr <= src_addr;
                    dst_ptr <= dst_addr;
                    count   <= len;
                end
                READ:  data_buf <= mem_dat_out;
                WRITE: begin
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                    count   <= count - AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    dmem_port_mux #(.AW(AW), .DW(DW)) u_port_mux (
        .rst_n      (rst_n),
        .state      (state),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_addr   (cpu_addr),
        .cpu_dat_in (cpu_dat_in),
        .src_ptr    (src_ptr),
        .dst_ptr    (dst_ptr),
        .data_buf   (data_buf),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat_in (mem_dat_in)
    );

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine with a behavioural 256x8 memory behind it.
module tb_dmem_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n, start, cpu_wr_en;
    logic [7:0] src_addr, dst_addr, len, cpu_addr, cpu_dat_in;
    logic [7:0] mem_dat_out, mem_addr, mem_dat_in;
    logic       mem_wr_en, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t exp_q[$];

    typedef struct { logic [7:0] src; logic [7:0] dst; logic [7:0] len; int lat; } vec_t;
    vec_t vecs[6];

    logic [7:0] dat_mem [256];
    logic [7:0] model   [256];

    always #5 clk = ~clk;

    dmem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_dat_in(cpu_dat_in),
        .mem_dat_out(mem_dat_out), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_dat_in(mem_dat_in), .busy(busy), .done(done)
    );

    // Memory behind the engine: combinational read, write on clock edge.
    assign mem_dat_out = dat_mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) dat_mem[mem_addr] <= mem_dat_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every memory write strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_dat_in);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, w.addr});
                chk("wr_data", {24'd0, mem_dat_in}, {24'd0, w.data});
            end
        end
    end

    // Reference copy: strictly ascending, byte at a time, pointers wrap at 8 bits.
    task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] sa, da;
            wr_t w;
            sa = s + 8'(i);
            da = d + 8'(i);
            model[da] = model[sa];
            w.addr = da; w.data = model[da];
            exp_q.push_back(w);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        @(posedge clk); #2;
        cpu_wr_en = 1'b1; cpu_addr = a; cpu_dat_in = d;
        model[a] = d;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic cpu_idle();
        @(posedge clk); #2;
        cpu_wr_en = 1'b0;
    endtask

    // Issue a copy and measure cycles from the start edge until done, plus busy cycles before it.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            output int lat, output int bcyc, output logic bdone);
        @(posedge clk); #2;
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        push_copy(s, d, int'(l));
        @(posedge clk); #2;
        start = 1'b0;
        lat = 0; bcyc = 0; bdone = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            lat++;
            if (done) begin bdone = busy; break; end
            if (busy) bcyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL copy_timeout src=%0h dst=%0h len=%0d", s, d, l);
        end
    endtask

    initial begin
        int lat, bcyc;
        logic bdone;
        logic [7:0] a;

        vecs[0] = '{8'h10, 8'h80, 8'd4, 9};
        vecs[1] = '{8'h20, 8'h40, 8'd0, 1};
        vecs[2] = '{8'hFE, 8'hEE, 8'd4, 9};
        vecs[3] = '{8'hEE, 8'hFE, 8'd4, 9};
        vecs[4] = '{8'h30, 8'h31, 8'd3, 7};
        vecs[5] = '{8'h60, 8'h60, 8'd5, 11};

        // Reset state: CPU store must be suppressed while rst_n is low.
        rst_n = 1'b0; start = 1'b0; src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00;
        cpu_wr_en = 1'b1; cpu_addr = 8'h12; cpu_dat_in = 8'h34;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'h12);
        chk("rst_dat", {24'd0, mem_dat_in}, 32'h34);
        repeat (2) @(negedge clk);
        cpu_wr_en = 1'b0;
        rst_n = 1'b1;

        // Fill memory through the CPU port, then the specific preload patterns.
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'(i) ^ 8'h5A);
        cpu_write(8'h10, 8'hA1); cpu_write(8'h11, 8'hB2);
        cpu_write(8'h12, 8'hC3); cpu_write(8'h13, 8'hD4);
        cpu_write(8'hFE, 8'h11); cpu_write(8'hFF, 8'h22);
        cpu_write(8'h00, 8'h33); cpu_write(8'h01, 8'h44);
        cpu_write(8'h30, 8'h5A); cpu_write(8'h31, 8'h00);
        cpu_write(8'h32, 8'h00); cpu_write(8'h33, 8'h00);
        cpu_idle();

        // Table-driven copies.
        for (int v = 0; v < 6; v++) begin
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, lat, bcyc, bdone);
            chk("done_latency", lat, vecs[v].lat);
            chk("busy_cycles", bcyc, vecs[v].lat - 1);
            chk("busy_in_done", {31'd0, bdone}, 32'd1);
            @(negedge clk);
            chk("idle_after_done", {30'd0, busy, done}, 32'd0);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].dst + 8'(i);
                chk("copy_dst", {24'd0, dat_mem[a]}, {24'd0, model[a]});
            end
        end
        chk("len0_untouched", {24'd0, dat_mem[8'h40]}, {24'd0, 8'h40 ^ 8'h5A});
        chk("t1_80", {24'd0, dat_mem[8'h80]}, 32'hA1);
        chk("t1_83", {24'd0, dat_mem[8'h83]}, 32'hD4);
        chk("t3_EE", {24'd0, dat_mem[8'hEE]}, 32'h11);
        chk("t3_F0", {24'd0, dat_mem[8'hF0]}, 32'h33);
        chk("t3_F1", {24'd0, dat_mem[8'hF1]}, 32'h44);
        chk("t3_wrap_01", {24'd0, dat_mem[8'h01]}, 32'h44);
        chk("t4_31", {24'd0, dat_mem[8'h31]}, 32'h5A);
        chk("t4_33", {24'd0, dat_mem[8'h33]}, 32'h5A);

        // Second start and CPU store while busy are both dropped.
        @(posedge clk); #2;
        start = 1'b1; src_addr = 8'h10; dst_addr = 8'hA0; len = 8'd3;
        push_copy(8'h10, 8'hA0, 3);
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'h08; len = 8'd5;
        cpu_wr_en = 1'b1; cpu_addr = 8'h90; cpu_dat_in = 8'hEE;
        lat = 1;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start_latency", lat, 7);
        @(posedge clk); #2;
        start = 1'b0; cpu_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_requeue_busy", {31'd0, busy}, 32'd0);
        end
        chk("busy_store_dropped", {24'd0, dat_mem[8'h90]}, {24'd0, 8'h90 ^ 8'h5A});
        cpu_write(8'h90, 8'hEE);
        cpu_idle();
        @(negedge clk);
        chk("idle_store", {24'd0, dat_mem[8'h90]}, 32'hEE);

        // Reset during the write of byte 2 of an 8-byte copy.
        @(posedge clk); #2;
        start = 1'b1; src_addr = 8'h50; dst_addr = 8'hC0; len = 8'd8;
        push_copy(8'h50, 8'hC0, 2);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_write", {23'd0, mem_wr_en, mem_addr}, {23'd0, 1'b1, 8'hC2});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", {30'd0, busy, done}, 32'd0);
        end
        chk("partial_b1", {24'd0, dat_mem[8'hC1]}, {24'd0, 8'h51 ^ 8'h5A});
        chk("partial_b2", {24'd0, dat_mem[8'hC2]}, {24'd0, 8'hC2 ^ 8'h5A});

        // Whole-memory compare catches any stray write.
        for (int i = 0; i < 256; i++)
            chk("mem_final", {24'd0, dat_mem[i]}, {24'd0, model[i]});
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
